zycap_icap_stream: RTL and testbench
====================================

// Module: zycap_icap_stream
// PURPOSE
// - Downstream of the zycap AXI-Lite control/status register block: consumes its mux_en/mux_drop/mux_sel/icap_rw
//   controls and returns the ICAP error status bit.
// - Selects one of N_SRC 32-bit AXI-Stream bitstream sources per packet and bit-swaps each byte.
// - Writes the words into the ICAPE3 primitive through a 1-deep registered output stage, or drops the packet.
// PARAMETERS
// - N_SRC       4   number of AXIS sources; 1..4, index = zycap_axis_mux_sel
// - DATA_WIDTH  32  AXIS/ICAP word width; fixed 32, other values unsupported
// PORTS
// - axis_aclk              in   1          single clock for all logic
// - axis_aresetn           in   1          reset, asynchronous assert, active-low
// - zycap_axis_mux_en      in   1          enable stream path
// - zycap_axis_mux_drop    in   1          1 = accept and discard packets
// - zycap_axis_mux_sel     in   2          source select, sampled at packet start
// - zycap_icap_rw          in   1          0 = write mode; 1 = read (stream path stalls)
// - zycap_icap_err_status  out  1          sticky ICAP error flag
// - s_axis_tdata           in   N_SRC*32   source words, src k at [32k+:32]
// - s_axis_tvalid          in   N_SRC      per-source valid
// - s_axis_tlast           in   N_SRC      per-source end of packet
// - s_axis_tready          out  N_SRC      per-source ready; only the selected bit may be 1
// - icap_csib              out  1          ICAP chip select, active-low
// - icap_rdwrb             out  1          ICAP 0 = write, 1 = read
// - icap_i                 out  32         ICAP write data
// - icap_avail             in   1          ICAP ready to accept
// - icap_prerror           in   1          ICAP partial-reconfiguration error
// BEHAVIOUR
// - Reset values
//   - Reset is asynchronous and active-low (decided).
//   - All outputs: state IDLE, tready=0, csib=1, rdwrb=0, icap_i=0, out_valid=0, err_status=0.
// - FSM states and transitions
//   - IDLE -> PASS when en & !drop & !rw & tvalid[sel] & sel<N_SRC. Latch sel into cur_sel.
//   - IDLE -> DROP when en & drop & tvalid[sel] & sel<N_SRC. Latch sel into cur_sel.
//   - sel>=N_SRC: stay IDLE, no tready asserted.
//   - PASS: tready[cur_sel] = !out_valid | icap_avail. On handshake, load out reg with bitswap(tdata); out_valid=1.
//   - PASS -> IDLE: on the handshake with tlast. The out reg still drains.
//   - PASS -> ABORT: when en falls mid-packet.
//   - DROP: tready[cur_sel]=1; beats are discarded with no ICAP access. DROP -> IDLE on the tlast handshake.
//   - ABORT: as DROP (discard to tlast). The pending out word is still written. ABORT -> IDLE on the tlast handshake.
// - Packet-level sampling
//   - sel and drop changes mid-packet are ignored until the next IDLE.
//   - en falling in DROP has no effect; DROP continues to tlast.
// - Bit-swap: icap_i[8k+b] = tdata[8k+7-b] for k=0..3, b=0..7.
// - Output stage and latency
//   - csib = ~(out_valid & icap_avail). A word is written and out_valid cleared in a cycle where both are 1.
//   - Latency: 1 cycle from AXIS handshake to csib low, when avail=1.
//   - Sustained throughput: 1 word/cycle.
//   - avail low: icap_i and out_valid hold. tready drops only if out_valid is already 1.
// - rdwrb: registered copy of zycap_icap_rw, updated only in IDLE with out_valid=0. Held constant during packets.
// - err_status
//   - Set on any cycle with icap_prerror=1.
//   - Cleared only in IDLE while en=0.
//   - Set has priority over clear in the same cycle.
// - Async reset mid-packet: immediate return to reset values. The pending word is lost; upstream re-sends.
// STRUCTURE
// - Shared package zycap_pkg:
//   - state enum {IDLE,PASS,DROP,ABORT}
//   - ICAP_WIDTH=32
//   - function bitswap32
//   - MAX_SRC=4
// - Sub-module zycap_icap_outreg: 1-deep output register with avail backpressure. Top holds FSM and mux.
// TESTING
// - Reset: hold aresetn=0 with random inputs -> csib=1, all tready=0, err_status=0. Release: no spurious write.
// - Pass: sel=2, en=1, 4-beat packet 0x01020304.. on src2, avail=1.
//   - icap_i=0x8040C020.. with csib low 1 cycle after each beat.
//   - Other tready=0; IDLE after the tlast beat.
// - Backpressure: avail=0 for 5 cycles mid-packet -> icap_i stable, exactly one word held, no loss or duplicate. Word order preserved.
// - Drop: drop=1, 8-beat packet -> tready=1 each beat, csib stays 1, IDLE after tlast.
// - Abort and sampling:
//   - en->0 after beat 2 of a 6-beat packet: beat 2 is still written; beats 3..6 are discarded.
//   - Change sel mid-packet: no effect until the next packet.
// - Error flag:
//   - Pulse prerror 1 cycle -> err_status=1 and stays 1 while en=1.
//   - en=0 in IDLE -> err_status=0 next cycle.
//   - prerror coincident with clear -> err_status stays 1.

Source files
------------

// File: rtl/zycap_pkg.sv
// Shared types and helpers for the zycap ICAP stream path: FSM state
// encoding, ICAP word width, source limit and the per-byte bit swap that
// ICAPE3 expects on its write data.
package zycap_pkg;

  localparam int ICAP_WIDTH = 32;
  localparam int MAX_SRC    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    DROP  = 2'd2,
    ABORT = 2'd3
  } zycap_state_e;

  // ICAPE3 takes each configuration byte with its bit order reversed.
  function automatic logic [ICAP_WIDTH-1:0] bitswap32(input logic [ICAP_WIDTH-1:0] d);
    logic [ICAP_WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 8; b++) begin
        r[8*k+b] = d[8*k+7-b];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/zycap_icap_stream_if.sv
// Bundle of the AXI-Stream bitstream sources and the ICAPE3 port.
// slave is the stream/ICAP block's view, master is the surrounding system
// (sources plus the ICAP primitive).
interface zycap_icap_stream_if #(
  parameter int N_SRC = 4
);

  logic [N_SRC*zycap_pkg::ICAP_WIDTH-1:0] s_axis_tdata;
  logic [N_SRC-1:0]                       s_axis_tvalid;
  logic [N_SRC-1:0]                       s_axis_tlast;
  logic [N_SRC-1:0]                       s_axis_tready;

  logic                                   icap_csib;
  logic                                   icap_rdwrb;
  logic [zycap_pkg::ICAP_WIDTH-1:0]       icap_i;
  logic                                   icap_avail;
  logic                                   icap_prerror;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output icap_csib, icap_rdwrb, icap_i,
    input  icap_avail, icap_prerror
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  icap_csib, icap_rdwrb, icap_i,
    output icap_avail, icap_prerror
  );

endinterface

// File: rtl/zycap_icap_outreg.sv
// One-word output register in front of ICAPE3. Holds the word until the
// primitive signals avail; chip select goes low only in the writing cycle.
module zycap_icap_outreg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  icap_avail,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] icap_i,
  output logic                  icap_csib
);

  logic write_now;

  assign write_now = out_valid & icap_avail;
  assign icap_csib = ~write_now;

  // Load a new word (the top only loads when the slot is free or emptying), otherwise clear valid once written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      icap_i    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      icap_i    <= load_data;
    end else if (write_now) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/zycap_icap_stream.sv
// Per-packet source selection, drop/abort handling and ICAP write path.
// The FSM picks a source at packet start and owns it until tlast; words in
// PASS are bit-swapped into the output register, DROP/ABORT discard beats.
module zycap_icap_stream
  import zycap_pkg::*;
#(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic               axis_aclk,
  input  logic               axis_aresetn,
  input  logic               zycap_axis_mux_en,
  input  logic               zycap_axis_mux_drop,
  input  logic [1:0]         zycap_axis_mux_sel,
  input  logic               zycap_icap_rw,
  output logic               zycap_icap_err_status,
  zycap_icap_stream_if.slave bus
);

  zycap_state_e          state, state_next;
  logic [1:0]            cur_sel;
  logic                  latch_sel;
  logic                  ready_cur;
  logic                  load;
  logic [MAX_SRC-1:0]    tvalid_pad;
  logic [MAX_SRC-1:0]    tlast_pad;
  logic                  sel_ok;
  logic                  sel_valid;
  logic                  cur_valid;
  logic                  cur_last;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [N_SRC-1:0]      ready_vec;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_word;
  logic                  out_csib;
  logic                  rdwrb_q;

  assign tvalid_pad = MAX_SRC'(bus.s_axis_tvalid);
  assign tlast_pad  = MAX_SRC'(bus.s_axis_tlast);
  assign sel_ok     = int'(zycap_axis_mux_sel) < N_SRC;
  assign sel_valid  = sel_ok & tvalid_pad[zycap_axis_mux_sel];
  assign cur_valid  = tvalid_pad[cur_sel];
  assign cur_last   = tlast_pad[cur_sel];

  // Data mux for the source owned by the current packet.
  always_comb begin
    cur_data = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (cur_sel == 2'(k)) cur_data = bus.s_axis_tdata[DATA_WIDTH*k +: DATA_WIDTH];
    end
  end

  // Next-state, per-packet ready and output-register load decisions.
  always_comb begin
    state_next = state;
    latch_sel  = 1'b0;
    ready_cur  = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (zycap_axis_mux_en && sel_valid) begin
          if (zycap_axis_mux_drop) begin
            latch_sel  = 1'b1;
            state_next = DROP;
          end else if (!zycap_icap_rw) begin
            latch_sel  = 1'b1;
            state_next = PASS;
          end
        end
      end
      PASS: begin
        if (!zycap_axis_mux_en) begin
          state_next = ABORT;
        end else begin
          ready_cur = ~out_valid | bus.icap_avail;
          load      = ready_cur & cur_valid;
          if (load && cur_last) state_next = IDLE;
        end
      end
      DROP, ABORT: begin
        ready_cur = 1'b1;
        if (cur_valid && cur_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Only the owned source ever sees ready.
  always_comb begin
    ready_vec = '0;
    for (int k = 0; k < N_SRC; k++) begin
      ready_vec[k] = ready_cur && (cur_sel == 2'(k));
    end
  end

  // State register and the source latched at packet start.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state   <= IDLE;
      cur_sel <= '0;
    end else begin
      state <= state_next;
      if (latch_sel) cur_sel <= zycap_axis_mux_sel;
    end
  end

  // Read/write direction only follows the control bit between packets with the output drained.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      rdwrb_q <= 1'b0;
    end else if (state == IDLE && !out_valid) begin
      rdwrb_q <= zycap_icap_rw;
    end
  end

  // Sticky PR error: any prerror sets it, clearing waits for software to disable the path while idle.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      zycap_icap_err_status <= 1'b0;
    end else if (bus.icap_prerror) begin
      zycap_icap_err_status <= 1'b1;
    end else if (state == IDLE && !zycap_axis_mux_en) begin
      zycap_icap_err_status <= 1'b0;
    end
  end

  zycap_icap_outreg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_outreg (
    .clk        (axis_aclk),
    .rst_n      (axis_aresetn),
    .load       (load),
    .load_data  (bitswap32(cur_data)),
    .icap_avail (bus.icap_avail),
    .out_valid  (out_valid),
    .icap_i     (out_word),
    .icap_csib  (out_csib)
  );

  assign bus.s_axis_tready = ready_vec;
  assign bus.icap_i        = out_word;
  assign bus.icap_csib     = out_csib;
  assign bus.icap_rdwrb    = rdwrb_q;

endmodule

// File: tb/tb_zycap_icap_stream.sv
// Scoreboard bench for zycap_icap_stream: expected ICAP words are queued
// as beats are accepted and popped whenever the ICAP is written.
module tb_zycap_icap_stream;

  localparam int N_SRC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       drop = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       rw = 1'b0;
  logic       err_status;

  zycap_icap_stream_if #(.N_SRC(N_SRC)) bus ();

  zycap_icap_stream #(
    .N_SRC      (N_SRC),
    .DATA_WIDTH (32)
  ) dut (
    .axis_aclk             (clk),
    .axis_aresetn          (rst_n),
    .zycap_axis_mux_en     (en),
    .zycap_axis_mux_drop   (drop),
    .zycap_axis_mux_sel    (sel),
    .zycap_icap_rw         (rw),
    .zycap_icap_err_status (err_status),
    .bus                   (bus)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb[$];
  int          cyc = 0;
  bit          hs_at[0:8191];
  int          act_src = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] tbSwap(input logic [31:0] w);
    logic [31:0] r;
    logic [7:0]  bt;
    for (int k = 0; k < 4; k++) begin
      bt = w[8*k +: 8];
      r[8*k +: 8] = {<<{bt}};
    end
    return r;
  endfunction

  // Monitor: every ICAP write must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.icap_csib === 1'b0) begin
        if (sb.size() == 0) checkOutput("spurious_write", 32'd1, 32'd0);
        else checkOutput("icap_word", bus.icap_i, sb.pop_front());
      end
      if (cyc > 0 && cyc < 8192 && hs_at[cyc-1] && bus.icap_avail === 1'b1)
        checkOutput("latency_csib", {31'd0, bus.icap_csib}, 32'd0);
      if (act_src >= 0)
        checkOutput("tready_other", {28'd0, bus.s_axis_tready & ~(4'b0001 << act_src)}, 32'd0);
    end
  end

  // Drive one packet on source src; the first pass_beats beats are expected on ICAP.
  task automatic applyStimulus(input int src, input int nbeats, input logic [31:0] base,
                               input int pass_beats, input int abort_at, input int stall_after,
                               input int resel_at, input logic [1:0] resel_val, input bit expect_immediate);
    logic [31:0] w;
    int          wait_cnt;
    bit          timed_out;
    bit          stall_pending;
    logic [31:0] hold_word;
    timed_out     = 1'b0;
    stall_pending = 1'b0;
    hold_word     = '0;
    act_src       = src;
    for (int i = 0; i < nbeats; i++) begin
      w = base + 32'h04040404 * i;
      if (i == abort_at) en = 1'b0;
      if (i == resel_at) sel = resel_val;
      bus.s_axis_tdata[32*src +: 32] = w;
      bus.s_axis_tvalid[src] = 1'b1;
      bus.s_axis_tlast[src]  = (i == nbeats - 1);
      if (stall_pending) begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          checkOutput("bp_hold_data", bus.icap_i, hold_word);
          checkOutput("bp_csib", {31'd0, bus.icap_csib}, 32'd1);
          checkOutput("bp_tready", {31'd0, bus.s_axis_tready[src]}, 32'd0);
        end
        @(posedge clk);
        #1 bus.icap_avail = 1'b1;
        stall_pending = 1'b0;
      end
      wait_cnt = 0;
      forever begin
        @(negedge clk);
        if (bus.s_axis_tready[src] === 1'b1) break;
        wait_cnt++;
        if (wait_cnt > 40) begin
          checkOutput("hs_timeout", 32'd1, 32'd0);
          timed_out = 1'b1;
          break;
        end
      end
      if (timed_out) break;
      if (expect_immediate && i > 0) checkOutput("ready_each_beat", wait_cnt, 32'd0);
      if (i < pass_beats) begin
        sb.push_back(tbSwap(w));
        if (cyc < 8192) hs_at[cyc] = 1'b1;
      end
      @(posedge clk);
      #1;
      if (i == stall_after) begin
        bus.icap_avail = 1'b0;
        stall_pending  = 1'b1;
        hold_word      = tbSwap(w);
      end
    end
    bus.s_axis_tvalid[src] = 1'b0;
    bus.s_axis_tlast[src]  = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_tlast", {31'd0, bus.s_axis_tready[src]}, 32'd0);
    act_src = -1;
  endtask

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tlast  = '0;
    bus.icap_avail    = 1'b1;
    bus.icap_prerror  = 1'b0;

    // Reset held with random inputs.
    for (int r = 0; r < 4; r++) begin
      @(posedge clk);
      #1;
      en   = 1'($urandom);
      drop = 1'($urandom);
      sel  = 2'($urandom);
      rw   = 1'($urandom);
      bus.s_axis_tvalid = 4'($urandom);
      bus.s_axis_tlast  = 4'($urandom);
      bus.s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
      bus.icap_prerror  = 1'($urandom);
      bus.icap_avail    = 1'($urandom);
      @(negedge clk);
      checkOutput("rst_csib", {31'd0, bus.icap_csib}, 32'd1);
      checkOutput("rst_tready", {28'd0, bus.s_axis_tready}, 32'd0);
      checkOutput("rst_err", {31'd0, err_status}, 32'd0);
      checkOutput("rst_icap_i", bus.icap_i, 32'd0);
      checkOutput("rst_rdwrb", {31'd0, bus.icap_rdwrb}, 32'd0);
    end
    @(posedge clk);
    #1;
    en = 1'b0; drop = 1'b0; sel = 2'd0; rw = 1'b0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tlast  = '0;
    bus.icap_prerror  = 1'b0;
    bus.icap_avail    = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post_rst_err", {31'd0, err_status}, 32'd0);

    // Straight pass on source 2.
    $display("[TB] pass packet on src2");
    en = 1'b1; drop = 1'b0; sel = 2'd2;
    applyStimulus(2, 4, 32'h01020304, 4, -1, -1, -1, 2'd0, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure in the middle of a packet on source 1.
    $display("[TB] backpressure packet on src1");
    sel = 2'd1;
    applyStimulus(1, 6, 32'h11223344, 6, -1, 2, -1, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Drop an 8-beat packet on source 0.
    $display("[TB] drop packet on src0");
    drop = 1'b1; sel = 2'd0;
    applyStimulus(0, 8, 32'hA5A5F00F, 0, -1, -1, -1, 2'd0, 1'b1);
    drop = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Abort: en falls after two beats, the rest are discarded.
    $display("[TB] abort packet on src3");
    sel = 2'd3;
    applyStimulus(3, 6, 32'h0F1E2D3C, 2, 2, -1, -1, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1 en = 1'b1;

    // sel change mid-packet is ignored; the next packet follows the new sel.
    $display("[TB] sel change mid-packet");
    sel = 2'd1;
    applyStimulus(1, 4, 32'h55AA1234, 4, -1, -1, 2, 2'd3, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(3, 3, 32'hC3C30001, 3, -1, -1, -1, 2'd0, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Read mode: rdwrb follows in idle and the stream path stays stalled.
    $display("[TB] read mode stall");
    rw = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rdwrb_read", {31'd0, bus.icap_rdwrb}, 32'd1);
    sel = 2'd0;
    bus.s_axis_tdata[31:0] = 32'hDEADBEEF;
    bus.s_axis_tvalid[0]   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("rw_stall_tready", {28'd0, bus.s_axis_tready}, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.s_axis_tvalid[0] = 1'b0;
    rw = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rdwrb_write", {31'd0, bus.icap_rdwrb}, 32'd0);

    // Sticky error flag, clear in idle with en low, set beats clear.
    $display("[TB] error flag");
    en = 1'b1;
    bus.icap_prerror = 1'b1;
    @(posedge clk);
    #1 bus.icap_prerror = 1'b0;
    @(negedge clk);
    checkOutput("err_set", {31'd0, err_status}, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("err_sticky", {31'd0, err_status}, 32'd1);
    @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("err_clear", {31'd0, err_status}, 32'd0);
    en = 1'b1;
    bus.icap_prerror = 1'b1;
    @(posedge clk);
    #1;
    bus.icap_prerror = 1'b0;
    checkOutput("err_set2", {31'd0, err_status}, 32'd1);
    en = 1'b0;
    bus.icap_prerror = 1'b1;
    @(posedge clk);
    #1;
    bus.icap_prerror = 1'b0;
    checkOutput("err_set_over_clear", {31'd0, err_status}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("err_clear2", {31'd0, err_status}, 32'd0);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
